// File: rtl/ast_dmx_package.sv
// Shared definitions for the Avalon-ST mux/demux blocks.
// Holds FSM state type, test case labels and a round-robin helper.
package ast_dmx_package;

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } mux_state_t;

    typedef enum logic [3:0] {
        DMX_BASIC,
        DMX_BACKPRESSURE,
        MUX_SINGLE,
        MUX_ALL_RR,
        MUX_ALTERNATE,
        MUX_BACKPRESSURE,
        MUX_ORPHAN,
        MUX_RESET
    } test_case_t;

    // Winner scanning from last+1 upward, mod n.
    // Returns last when nothing requests.
    function automatic int unsigned next_rr(
        input int unsigned n,
        input int unsigned last,
        input logic [31:0] req_mask
    );
        int unsigned res;
        logic        hit;
        res = last;
        hit = 1'b0;
        for (int unsigned i = 1; i <= n; i++) begin
            int unsigned idx;
            idx = (last + i) % n;
            if (!hit && req_mask[idx[4:0]]) begin
                res = idx;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ast_mux_rr_arb.sv
// Combinational round-robin arbiter for ast_mux.
// req_i: request mask; last_grant_i: previous winner; grant_o/any_req_o: result.
module ast_mux_rr_arb
    import ast_dmx_package::*;
#(
    parameter int RX_DIR = 4,
    parameter int SEL_W  = 2
) (
    input  logic [RX_DIR-1:0] req_i,
    input  logic [SEL_W-1:0]  last_grant_i,
    output logic [SEL_W-1:0]  grant_o,
    output logic              any_req_o
);

    logic found;

    always_comb begin
        grant_o   = '0;
        found     = 1'b0;
        any_req_o = |req_i;
        for (int i = 1; i <= RX_DIR; i++) begin
            int idx;
            idx = (int'(last_grant_i) + i) % RX_DIR;
            if (!found && req_i[idx]) begin
                grant_o = SEL_W'(idx);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ast_mux.sv
// Avalon-ST multiplexer: packet-granular round-robin merge of RX_DIR
// sinks into one registered source. Ports: clk_i, arst_n_i, ast_*_i
// per-input sink arrays, ast_ready_o per input, ast_*_o source, dir_o origin.
module ast_mux
    import ast_dmx_package::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i          [RX_DIR],
    input  logic                     ast_startofpacket_i [RX_DIR],
    input  logic                     ast_endofpacket_i   [RX_DIR],
    input  logic                     ast_valid_i         [RX_DIR],
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i         [RX_DIR],
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i       [RX_DIR],
    output logic                     ast_ready_o         [RX_DIR],
    output logic [DATA_WIDTH-1:0]    ast_data_o,
    output logic                     ast_startofpacket_o,
    output logic                     ast_endofpacket_o,
    output logic                     ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
    input  logic                     ast_ready_i,
    output logic [DIR_SEL_WIDTH-1:0] dir_o
);

    mux_state_t               state_q;
    logic [DIR_SEL_WIDTH-1:0] grant_q;
    logic [DIR_SEL_WIDTH-1:0] last_grant_q;
    logic [DIR_SEL_WIDTH-1:0] arb_grant;
    logic                     any_req;
    logic [RX_DIR-1:0]        req;
    logic [RX_DIR-1:0]        in_ready;
    logic                     out_free;
    logic                     accept;

    logic [DATA_WIDTH-1:0]    data_q;
    logic                     sop_q;
    logic                     eop_q;
    logic                     valid_q;
    logic [EMPTY_WIDTH-1:0]   empty_q;
    logic [CHANNEL_WIDTH-1:0] chan_q;
    logic [DIR_SEL_WIDTH-1:0] dir_q;

    always_comb begin
        req = '0;
        for (int k = 0; k < RX_DIR; k++) begin
            req[k] = ast_valid_i[k] && ast_startofpacket_i[k];
        end
    end

    ast_mux_rr_arb #(
        .RX_DIR (RX_DIR),
        .SEL_W  (DIR_SEL_WIDTH)
    ) u_arb (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (any_req)
    );

    assign out_free = !valid_q || ast_ready_i;

    // In IDLE, orphan words (no SOP) are drained so they cannot block
    // arbitration; requesters wait for the grant. Reset forces all low.
    always_comb begin
        in_ready = '0;
        if (arst_n_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    for (int k = 0; k < RX_DIR; k++) begin
                        in_ready[k] = ast_valid_i[k] && !ast_startofpacket_i[k];
                    end
                end
                ST_PKT: begin
                    in_ready[grant_q] = out_free;
                end
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < RX_DIR; k++) begin
            ast_ready_o[k] = in_ready[k];
        end
    end

    assign accept = (state_q == ST_PKT) && ast_valid_i[grant_q] && in_ready[grant_q];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= DIR_SEL_WIDTH'(RX_DIR - 1);
            data_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            valid_q      <= 1'b0;
            empty_q      <= '0;
            chan_q       <= '0;
            dir_q        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= arb_grant;
                        state_q <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (accept && ast_endofpacket_i[grant_q]) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
            endcase

            // Load wins over consume so back-to-back words keep valid high.
            if (accept) begin
                data_q  <= ast_data_i[grant_q];
                sop_q   <= ast_startofpacket_i[grant_q];
                eop_q   <= ast_endofpacket_i[grant_q];
                empty_q <= ast_empty_i[grant_q];
                chan_q  <= ast_channel_i[grant_q];
                dir_q   <= grant_q;
                valid_q <= 1'b1;
            end else if (ast_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ast_data_o          = data_q;
    assign ast_startofpacket_o = sop_q;
    assign ast_endofpacket_o   = eop_q;
    assign ast_valid_o         = valid_q;
    assign ast_empty_o         = empty_q;
    assign ast_channel_o       = chan_q;
    assign dir_o               = dir_q;

endmodule

// File: tb/tb_ast_mux.sv
// Directed self-checking bench for ast_mux.
// Per-input source queues feed the DUT; an output log is checked.
module tb_ast_mux;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [7:0]  chan;
    } word_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [7:0]  chan;
        logic [1:0]  dir;
        int          cyc;
    } oword_t;

    logic        clk;
    logic        arst_n;
    logic [63:0] data_i  [4];
    logic        sop_i   [4];
    logic        eop_i   [4];
    logic        valid_i [4];
    logic [2:0]  empty_i [4];
    logic [7:0]  chan_i  [4];
    logic        ready_o [4];
    logic [63:0] data_o;
    logic        sop_o;
    logic        eop_o;
    logic        valid_o;
    logic [2:0]  empty_o;
    logic [7:0]  chan_o;
    logic        ready_i;
    logic [1:0]  dir_o;

    word_t  src [4][$];
    oword_t outq[$];
    logic   fire [4];
    int     cyc;
    int     checks;
    int     errors;

    ast_mux u_dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .ast_data_i          (data_i),
        .ast_startofpacket_i (sop_i),
        .ast_endofpacket_i   (eop_i),
        .ast_valid_i         (valid_i),
        .ast_empty_i         (empty_i),
        .ast_channel_i       (chan_i),
        .ast_ready_o         (ready_o),
        .ast_data_o          (data_o),
        .ast_startofpacket_o (sop_o),
        .ast_endofpacket_o   (eop_o),
        .ast_valid_o         (valid_o),
        .ast_empty_o         (empty_o),
        .ast_channel_o       (chan_o),
        .ast_ready_i         (ready_i),
        .dir_o               (dir_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rdy_vec();
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = ready_o[k];
        return r;
    endfunction

    function automatic oword_t out_at(input int i);
        oword_t o;
        o = '{default: '0};
        if (i < outq.size()) o = outq[i];
        return o;
    endfunction

    task automatic push(input int k, input logic [63:0] d, input logic s,
                        input logic e, input logic [2:0] em,
                        input logic [7:0] ch);
        word_t w;
        w.data  = d;
        w.sop   = s;
        w.eop   = e;
        w.empty = em;
        w.chan  = ch;
        src[k].push_back(w);
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (src[k].size() > 0) begin
                valid_i[k] = 1'b1;
                data_i[k]  = src[k][0].data;
                sop_i[k]   = src[k][0].sop;
                eop_i[k]   = src[k][0].eop;
                empty_i[k] = src[k][0].empty;
                chan_i[k]  = src[k][0].chan;
            end else begin
                valid_i[k] = 1'b0;
                data_i[k]  = '0;
                sop_i[k]   = 1'b0;
                eop_i[k]   = 1'b0;
                empty_i[k] = '0;
                chan_i[k]  = '0;
            end
        end
    endtask

    // Handshakes are observed mid-cycle where everything is settled.
    task automatic sample();
        oword_t o;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 4; k++) fire[k] = valid_i[k] && ready_o[k];
        if (valid_o && ready_i) begin
            o.data  = data_o;
            o.sop   = sop_o;
            o.eop   = eop_o;
            o.empty = empty_o;
            o.chan  = chan_o;
            o.dir   = dir_o;
            o.cyc   = cyc;
            outq.push_back(o);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (fire[k]) void'(src[k].pop_front());
        end
        drive();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (outq.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk({tag, "_count"}, 64'(outq.size()), 64'(n));
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        for (int k = 0; k < 4; k++) src[k].delete();
        drive();
        outq.delete();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] exp2 [8];
        logic [63:0] exp3 [5];
        logic [1:0]  dir3 [5];
        logic [63:0] d1   [3];
        oword_t      o;

        clk     = 1'b0;
        arst_n  = 1'b0;
        ready_i = 1'b1;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        for (int k = 0; k < 4; k++) fire[k] = 1'b0;
        drive();
        #2;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_sop_eop", 64'({sop_o, eop_o}), 64'd0);
        chk("rst_empty_chan", 64'({empty_o, chan_o}), 64'd0);
        chk("rst_dir", 64'(dir_o), 64'd0);
        chk("rst_ready", 64'(rdy_vec()), 64'd0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // single 3-word packet on input 0
        d1[0] = 64'h11;
        d1[1] = 64'h22;
        d1[2] = 64'h33;
        push(0, 64'h11, 1'b1, 1'b0, 3'd0, 8'd5);
        push(0, 64'h22, 1'b0, 1'b0, 3'd0, 8'd5);
        push(0, 64'h33, 1'b0, 1'b1, 3'd2, 8'd5);
        drive();
        sample();
        chk("t1_idle_rdy", 64'(ready_o[0]), 64'd0);
        chk("t1_idle_vld", 64'(valid_o), 64'd0);
        advance();
        sample();
        chk("t1_pkt_rdy", 64'(ready_o[0]), 64'd1);
        chk("t1_pkt_vld", 64'(valid_o), 64'd0);
        advance();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk($sformatf("t1_vld%0d", i), 64'(valid_o), 64'd1);
            chk($sformatf("t1_data%0d", i), data_o, d1[i]);
            chk($sformatf("t1_sop%0d", i), 64'(sop_o), 64'(i == 0));
            chk($sformatf("t1_eop%0d", i), 64'(eop_o), 64'(i == 2));
            chk($sformatf("t1_empty%0d", i), 64'(empty_o), (i == 2) ? 64'd2 : 64'd0);
            chk($sformatf("t1_chan%0d", i), 64'(chan_o), 64'd5);
            chk($sformatf("t1_dir%0d", i), 64'(dir_o), 64'd0);
            advance();
        end
        sample();
        chk("t1_end_vld", 64'(valid_o), 64'd0);
        advance();

        // all four inputs request at once, 2-word packets
        do_reset();
        exp2 = '{64'hA0, 64'hA1, 64'hB0, 64'hB1,
                 64'hC0, 64'hC1, 64'hD0, 64'hD1};
        for (int k = 0; k < 4; k++) begin
            push(k, exp2[2*k], 1'b1, 1'b0, 3'd0, 8'(k));
            push(k, exp2[2*k+1], 1'b0, 1'b1, 3'd1, 8'(k));
        end
        drive();
        wait_out("t2", 8, 60);
        for (int j = 0; j < 8; j++) begin
            o = out_at(j);
            chk($sformatf("t2_data%0d", j), o.data, exp2[j]);
            chk($sformatf("t2_dir%0d", j), 64'(o.dir), 64'(j / 2));
            chk($sformatf("t2_chan%0d", j), 64'(o.chan), 64'(j / 2));
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("t2_atomic%0d", p),
                64'(out_at(2*p+1).cyc - out_at(2*p).cyc), 64'd1);
        end
        for (int p = 1; p < 4; p++) begin
            chk($sformatf("t2_bubble%0d", p),
                64'(out_at(2*p).cyc - out_at(2*p-1).cyc), 64'd2);
        end

        // inputs 1 and 3 keep requesting: 1,3,1,3,1
        do_reset();
        exp3 = '{64'h1A, 64'h3A, 64'h1B, 64'h3B, 64'h1C};
        dir3 = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        push(1, 64'h1A, 1'b1, 1'b1, 3'd0, 8'd1);
        push(1, 64'h1B, 1'b1, 1'b1, 3'd0, 8'd1);
        push(1, 64'h1C, 1'b1, 1'b1, 3'd0, 8'd1);
        push(3, 64'h3A, 1'b1, 1'b1, 3'd0, 8'd3);
        push(3, 64'h3B, 1'b1, 1'b1, 3'd0, 8'd3);
        drive();
        wait_out("t3", 5, 40);
        for (int j = 0; j < 5; j++) begin
            o = out_at(j);
            chk($sformatf("t3_data%0d", j), o.data, exp3[j]);
            chk($sformatf("t3_dir%0d", j), 64'(o.dir), 64'(dir3[j]));
            chk($sformatf("t3_sopeop%0d", j), 64'({o.sop, o.eop}), 64'd3);
        end

        // backpressure for 5 cycles mid-packet
        do_reset();
        push(0, 64'h41, 1'b1, 1'b0, 3'd0, 8'd9);
        push(0, 64'h42, 1'b0, 1'b0, 3'd0, 8'd9);
        push(0, 64'h43, 1'b0, 1'b0, 3'd0, 8'd9);
        push(0, 64'h44, 1'b0, 1'b1, 3'd4, 8'd9);
        drive();
        wait_out("t4_first", 1, 20);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk($sformatf("t4_hold_vld%0d", i), 64'(valid_o), 64'd1);
            chk($sformatf("t4_hold_data%0d", i), data_o, 64'h42);
            chk($sformatf("t4_hold_rdy%0d", i), 64'(ready_o[0]), 64'd0);
            advance();
        end
        ready_i = 1'b1;
        wait_out("t4", 4, 20);
        repeat (3) tick();
        chk("t4_total", 64'(outq.size()), 64'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t4_data%0d", j), out_at(j).data, 64'h41 + 64'(j));
        end

        // orphan word on input 2 while idle
        do_reset();
        push(2, 64'h77, 1'b0, 1'b0, 3'd0, 8'd2);
        drive();
        sample();
        chk("t5_orphan_rdy", 64'(rdy_vec()), 64'b0100);
        advance();
        repeat (4) tick();
        chk("t5_no_out", 64'(outq.size()), 64'd0);
        chk("t5_drained", 64'(src[2].size()), 64'd0);
        chk("t5_vld", 64'(valid_o), 64'd0);

        // reset during the 2nd word of a 4-word packet
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 64'h61 + 64'(i), i == 0, i == 3, 3'd0, 8'd6);
        end
        drive();
        wait_out("t6_first", 1, 20);
        chk("t6_pre_vld", 64'(valid_o), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 64'(valid_o), 64'd0);
        chk("t6_rst_data", data_o, 64'd0);
        chk("t6_rst_misc", 64'({sop_o, eop_o, empty_o, chan_o, dir_o}), 64'd0);
        chk("t6_rst_ready", 64'(rdy_vec()), 64'd0);
        for (int k = 0; k < 4; k++) src[k].delete();
        outq.delete();
        drive();
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        push(1, 64'h81, 1'b1, 1'b1, 3'd0, 8'd1);
        push(0, 64'h91, 1'b1, 1'b1, 3'd0, 8'd0);
        drive();
        wait_out("t6", 2, 20);
        chk("t6_first_dir", 64'(out_at(0).dir), 64'd0);
        chk("t6_first_data", out_at(0).data, 64'h91);
        chk("t6_second_dir", 64'(out_at(1).dir), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ast_mux.md
Name: ast_mux

Overview:
- Avalon-ST multiplexer, the counterpart of ast_dmx: merges RX_DIR sink streams into one source stream.
- Arbitration is packet-granular round-robin. Once an input is granted, its packet passes uninterrupted from SOP to EOP.
- Output is registered: one-stage output register with backpressure.
- dir_o reports which input produced the current output word, so a downstream ast_dmx can route it back by origin.

Parameters:
DATA_WIDTH, 64, data bus width in bits (multiple of 8)
CHANNEL_WIDTH, 8, channel field width
EMPTY_WIDTH, $clog2(DATA_WIDTH/8), empty field width
RX_DIR, 4, number of input streams (>=1)
DIR_SEL_WIDTH, RX_DIR==1 ? 1 : $clog2(RX_DIR), width of dir_o

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous reset, active-low
ast_data_i  in  DATA_WIDTH x [RX_DIR]  input data, unpacked array
ast_startofpacket_i  in  1 x [RX_DIR]  SOP per input
ast_endofpacket_i  in  1 x [RX_DIR]  EOP per input
ast_valid_i  in  1 x [RX_DIR]  valid per input
ast_empty_i  in  EMPTY_WIDTH x [RX_DIR]  empty per input
ast_channel_i  in  CHANNEL_WIDTH x [RX_DIR]  channel per input
ast_ready_o  out  1 x [RX_DIR]  ready per input
ast_data_o  out  DATA_WIDTH  output data
ast_startofpacket_o  out  1  output SOP
ast_endofpacket_o  out  1  output EOP
ast_valid_o  out  1  output valid
ast_empty_o  out  EMPTY_WIDTH  output empty
ast_channel_o  out  CHANNEL_WIDTH  output channel, passed through unchanged
ast_ready_i  in  1  downstream ready
dir_o  out  DIR_SEL_WIDTH  source input index of the current output word

Behaviour:
- Reset (arst_n_i=0, takes effect immediately, no clock needed):
  - All outputs 0, including ast_ready_o and dir_o.
  - State IDLE; last_grant = RX_DIR-1, so input 0 has top priority after reset.
- Transfer rules:
  - An input word transfers when ast_valid_i[k] && ast_ready_o[k].
  - An output word transfers when ast_valid_o && ast_ready_i.
- State IDLE:
  - Requesters are inputs with valid && startofpacket.
  - If any requester exists: grant the first one found scanning from last_grant+1 upward, mod RX_DIR. Register grant; go to PKT next cycle.
  - Inputs with valid && !startofpacket (orphan words) get ast_ready_o=1 in IDLE and are discarded; they never reach the output.
  - Requesters get ast_ready_o=0 in IDLE.
- State PKT:
  - ast_ready_o[grant] = !ast_valid_o || ast_ready_i. All other ready outputs are 0.
  - Each accepted word is loaded into the output register: data, sop, eop, empty, channel, and dir_o=grant.
  - When an accepted word has eop=1: last_grant <= grant; go to IDLE.
  - A mid-packet SOP without a preceding EOP is forwarded unchanged; there is no recovery, and the packet ends at the next EOP.
- Latency and throughput:
  - 1 cycle from input accept to ast_valid_o.
  - Full throughput within a packet when ast_ready_i=1.
  - Exactly one bubble cycle (the IDLE arbitration cycle) between consecutive packets.
- Output register:
  - Load takes priority. If output is consumed and a new word is accepted in the same cycle, the register is reloaded and valid stays 1.
  - If output is consumed with no load, valid goes to 0.
  - Output fields hold stable while valid && !ready.
- RX_DIR=1: grant is always 0 and dir_o is always 0; behaviour is otherwise unchanged.
- Single-word packet (sop=eop=1): the PKT state lasts exactly the accept cycle, then returns to IDLE.
- Reset mid-packet: the partial packet is dropped and the output register is cleared. Upstream must resend.

Decomposition:
- Shared package ast_dmx_package:
  - Add MUX_* entries to the test_case enum.
  - Add function next_rr(last, req_mask) for reuse by bench models.
- Sub-module ast_mux_rr_arb: combinational round-robin arbiter.
  - Inputs: req[RX_DIR], last_grant.
  - Outputs: grant index, any_req.
- ast_mux holds the FSM and the output register.

Test Plan:
- Single input 0 sends a 3-word packet (0x11, 0x22, 0x33; sop on word 1, eop on word 3; empty=2; channel=5), ast_ready_i=1 -> output shows the same 3 words on 3 consecutive cycles starting 2 cycles after the first valid (1 IDLE cycle + 1 register cycle); dir_o=0; empty=2 on the last word; channel=5 on all words.
- All 4 inputs hold a 2-word packet from the same cycle -> output packet order is inputs 0,1,2,3; each packet is atomic; one bubble cycle between packets.
- Inputs 1 and 3 continuously request after a packet from input 1 -> next grant is input 3, then 1, then 3 (alternating).
- ast_ready_i=0 for 5 cycles mid-packet -> output fields held stable; ast_ready_o[grant]=0; no word lost or duplicated after release.
- Orphan word (valid=1, sop=0) on input 2 in IDLE -> ast_ready_o[2]=1 for that cycle; nothing appears on the output.
- arst_n_i pulsed low during the 2nd word of a 4-word packet -> all outputs 0 immediately; after release, a new packet from input 0 is granted first.
